// File: rtl/hipass_lane_timer.sv
// Multi-lane hipass tag-wait timer: each lane arms, waits for a tag or times out,
// and holds a PASS/MISS verdict code (sent through a DELAY-stage pipe) until acknowledged.
module hipass_lane_timer #(
  parameter int               LANES     = 2,
  parameter int               CNT_W     = 3,
  parameter int               TIMEOUT   = 7,
  parameter int               CODE_W    = 4,
  parameter logic [CODE_W-1:0] PASS_CODE = 4'b1111,
  parameter logic [CODE_W-1:0] MISS_CODE = 4'b0101,
  parameter int               DELAY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*LANES-1:0]        en,
  input  logic [LANES-1:0]          car,
  input  logic [LANES-1:0]          ack,
  output logic [LANES-1:0]          busy,
  output logic [LANES-1:0]          evt,
  output logic [LANES*CODE_W-1:0]   hipass_in
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, PASS = 2'd2, MISS = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                  state_r    [LANES];
  state_t                  state_nx_s [LANES];
  logic [CNT_W-1:0]        cnt_r      [LANES];
  logic [CNT_W-1:0]        cnt_nx_s   [LANES];
  logic [LANES*CODE_W-1:0] code_nx_s;
  logic [LANES-1:0]        evt_nx_s;
  logic [LANES-1:0]        busy_nx_s;
  logic [LANES*CODE_W-1:0] code_pipe_r [DELAY+1];
  logic [LANES-1:0]        evt_pipe_r  [DELAY+1];
  logic [LANES-1:0]        busy_r;

  // Per-lane state and wait-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_r[i] <= state_nx_s[i];
        cnt_r[i]   <= cnt_nx_s[i];
      end
    end
  end

  // Per-lane next state: cancel > pause > tag > timeout > count
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      case (state_r[i])
        IDLE: begin
          if (en[2*i +: 2] == 2'b10) begin
            state_nx_s[i] = WAIT;
            cnt_nx_s[i]   = '0;
          end else begin
            state_nx_s[i] = IDLE;
          end
        end
        WAIT: begin
          if (en[2*i +: 2] == 2'b00) begin
            state_nx_s[i] = IDLE;
            cnt_nx_s[i]   = '0;
          end else if (en[2*i] == 1'b1) begin
            state_nx_s[i] = WAIT;
          end else if (car[i]) begin
            state_nx_s[i] = PASS;
          end else if (cnt_r[i] == CNT_LAST) begin
            state_nx_s[i] = MISS;
          end else begin
            cnt_nx_s[i] = cnt_r[i] + CNT_W'(1);
          end
        end
        PASS, MISS: begin
          if (ack[i] || (en[2*i +: 2] == 2'b00)) begin
            state_nx_s[i] = IDLE;
            cnt_nx_s[i]   = '0;
          end else begin
            state_nx_s[i] = state_r[i];
          end
        end
        default: begin
          state_nx_s[i] = IDLE;
          cnt_nx_s[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from next state so codes move on the same edge as the state
  always_comb begin
    code_nx_s = '0;
    evt_nx_s  = '0;
    busy_nx_s = '0;
    for (int i = 0; i < LANES; i++) begin
      case (state_nx_s[i])
        PASS:    code_nx_s[i*CODE_W +: CODE_W] = PASS_CODE;
        MISS:    code_nx_s[i*CODE_W +: CODE_W] = MISS_CODE;
        default: code_nx_s[i*CODE_W +: CODE_W] = '0;
      endcase
      evt_nx_s[i]  = ((state_nx_s[i] == PASS) || (state_nx_s[i] == MISS)) &&
                     !((state_r[i] == PASS) || (state_r[i] == MISS));
      busy_nx_s[i] = (state_nx_s[i] != IDLE);
    end
  end

  // Code/event register plus DELAY extra stages; busy stays undelayed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d <= DELAY; d++) begin
        code_pipe_r[d] <= '0;
        evt_pipe_r[d]  <= '0;
      end
      busy_r <= '0;
    end else begin
      code_pipe_r[0] <= code_nx_s;
      evt_pipe_r[0]  <= evt_nx_s;
      for (int d = 1; d <= DELAY; d++) begin
        code_pipe_r[d] <= code_pipe_r[d-1];
        evt_pipe_r[d]  <= evt_pipe_r[d-1];
      end
      busy_r <= busy_nx_s;
    end
  end

  assign hipass_in = code_pipe_r[DELAY];
  assign evt       = evt_pipe_r[DELAY];
  assign busy      = busy_r;

endmodule

// File: tb/tb_hipass_lane_timer.sv
// Self-checking bench: default instance (2 lanes, TIMEOUT 7, DELAY 1) and a
// swept instance (4 lanes, TIMEOUT 1, DELAY 0), checked against a lane model.
module tb_hipass_lane_timer;

  logic        clk;
  logic        rst;
  logic [3:0]  en_a;
  logic [1:0]  car_a, ack_a, busy_a, evt_a;
  logic [7:0]  hip_a;
  logic [7:0]  en_b;
  logic [3:0]  car_b, ack_b, busy_b, evt_b;
  logic [15:0] hip_b;

  int errors = 0;
  int checks = 0;

  hipass_lane_timer dut_a (
    .clk(clk), .rst(rst), .en(en_a), .car(car_a), .ack(ack_a),
    .busy(busy_a), .evt(evt_a), .hipass_in(hip_a)
  );

  hipass_lane_timer #(.LANES(4), .TIMEOUT(1), .DELAY(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .car(car_b), .ack(ack_b),
    .busy(busy_b), .evt(evt_b), .hipass_in(hip_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane model: phase, cycles already waited, and a history of emitted codes/events
  localparam int P_IDLE = 0, P_WAIT = 1, P_PASS = 2, P_MISS = 3;
  int         m_ph     [2][4];
  int         m_waited [2][4];
  logic [3:0] m_code   [2][4][5];
  logic       m_evt    [2][4][5];

  task automatic model_reset();
    for (int n = 0; n < 2; n++)
      for (int l = 0; l < 4; l++) begin
        m_ph[n][l] = P_IDLE;
        m_waited[n][l] = 0;
        for (int d = 0; d < 5; d++) begin
          m_code[n][l][d] = 4'h0;
          m_evt[n][l][d]  = 1'b0;
        end
      end
  endtask

  task automatic model_step();
    int old, lim;
    logic [1:0] md;
    logic c, a;
    logic [7:0] en_pad;
    logic [3:0] car_pad, ack_pad;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 2; n++)
      for (int l = 0; l < 4; l++) begin
        lim     = (n == 0) ? 7 : 1;
        en_pad  = (n == 0) ? {4'b0000, en_a} : en_b;
        car_pad = (n == 0) ? {2'b00, car_a} : car_b;
        ack_pad = (n == 0) ? {2'b00, ack_a} : ack_b;
        md  = en_pad[2*l +: 2];
        c   = car_pad[l];
        a   = ack_pad[l];
        old = m_ph[n][l];
        if (old == P_IDLE) begin
          if (md == 2'b10) begin m_ph[n][l] = P_WAIT; m_waited[n][l] = 0; end
        end else if (old == P_WAIT) begin
          if (md == 2'b00) m_ph[n][l] = P_IDLE;
          else if (md[0]) m_ph[n][l] = P_WAIT;
          else if (c) m_ph[n][l] = P_PASS;
          else if (m_waited[n][l] + 1 >= lim) m_ph[n][l] = P_MISS;
          else m_waited[n][l] = m_waited[n][l] + 1;
        end else begin
          if (a || md == 2'b00) m_ph[n][l] = P_IDLE;
        end
        for (int d = 4; d > 0; d--) begin
          m_code[n][l][d] = m_code[n][l][d-1];
          m_evt[n][l][d]  = m_evt[n][l][d-1];
        end
        m_code[n][l][0] = (m_ph[n][l] == P_PASS) ? 4'hF :
                          (m_ph[n][l] == P_MISS) ? 4'h5 : 4'h0;
        m_evt[n][l][0]  = (m_ph[n][l] >= P_PASS) && (old < P_PASS);
      end
  endtask

  function automatic logic [15:0] exp_hip(int n);
    logic [15:0] r = 16'h0;
    for (int l = 0; l < 4; l++) r[4*l +: 4] = m_code[n][l][(n == 0) ? 1 : 0];
    return r;
  endfunction

  function automatic logic [3:0] exp_evt(int n);
    logic [3:0] r = 4'h0;
    for (int l = 0; l < 4; l++) r[l] = m_evt[n][l][(n == 0) ? 1 : 0];
    return r;
  endfunction

  function automatic logic [3:0] exp_busy(int n);
    logic [3:0] r = 4'h0;
    for (int l = 0; l < 4; l++) r[l] = (m_ph[n][l] != P_IDLE);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    en_a = 4'h0; car_a = 2'b00; ack_a = 2'b00;
    en_b = 8'h00; car_b = 4'h0; ack_b = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) tick();
    checks++;
    if ({busy_a, evt_a, hip_a, busy_b, evt_b, hip_b} !== 36'h0) begin
      errors++; $display("FAIL rst_hold got=%h exp=0", {busy_a, evt_a, hip_a, busy_b, evt_b, hip_b});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy_a, evt_a, hip_a, busy_b, evt_b, hip_b} !== 36'h0) begin
      errors++; $display("FAIL rst_release got=%h exp=0", {busy_a, evt_a, hip_a, busy_b, evt_b, hip_b});
    end
    en_a = 4'b0010;
    tick();
    checks++;
    if (busy_a !== 2'b01) begin errors++; $display("FAIL arm_busy got=%b exp=01", busy_a); end
    repeat (3) tick();
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({busy_a, evt_a, hip_a} !== 12'h0) begin
      errors++; $display("FAIL rst_midwait got=%h exp=0", {busy_a, evt_a, hip_a});
    end
    en_a = 4'h0;
    tick();
    rst = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if ({evt_a, hip_a} !== 10'h0) begin
        errors++; $display("FAIL rst_noverdict t=%0d got=%h exp=0", t, {evt_a, hip_a});
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] eh;
    en_a = 4'b0010;
    for (int t = 1; t <= 12; t++) begin
      tick();
      eh = (t >= 9) ? 4'h5 : 4'h0;
      checks++;
      if (hip_a[3:0] !== eh || evt_a[0] !== (t == 9) || busy_a[0] !== 1'b1) begin
        errors++;
        $display("FAIL timeout t=%0d got code=%h evt=%b busy=%b exp code=%h evt=%b busy=1",
                 t, hip_a[3:0], evt_a[0], busy_a[0], eh, (t == 9));
      end
    end
    en_a = 4'b0001; ack_a = 2'b01;
    tick();
    checks++;
    if (busy_a[0] !== 1'b0 || hip_a[3:0] !== 4'h5) begin
      errors++; $display("FAIL ack_busy got busy=%b code=%h exp busy=0 code=5", busy_a[0], hip_a[3:0]);
    end
    ack_a = 2'b00;
    tick();
    checks++;
    if (hip_a[3:0] !== 4'h0 || busy_a[0] !== 1'b0) begin
      errors++; $display("FAIL ack_code got code=%h busy=%b exp 0", hip_a[3:0], busy_a[0]);
    end
    en_a = 4'h0;
    tick();
  endtask

  task automatic test_tie();
    logic [3:0] eh;
    en_a = 4'b1000;
    for (int t = 1; t <= 10; t++) begin
      car_a = (t == 8) ? 2'b10 : 2'b00;
      tick();
      eh = (t >= 9) ? 4'hF : 4'h0;
      checks++;
      if (hip_a[7:4] !== eh || evt_a[1] !== (t == 9)) begin
        errors++;
        $display("FAIL tie t=%0d got code=%h evt=%b exp code=%h evt=%b", t, hip_a[7:4], evt_a[1], eh, (t == 9));
      end
    end
    car_a = 2'b00; en_a = 4'b0100; ack_a = 2'b10;
    tick();
    ack_a = 2'b00;
    tick();
    checks++;
    if ({busy_a, hip_a} !== 10'h0) begin
      errors++; $display("FAIL tie_ack got=%h exp=0", {busy_a, hip_a});
    end
    en_a = 4'h0;
  endtask

  task automatic test_pause_cancel();
    logic [3:0] eh;
    for (int t = 1; t <= 14; t++) begin
      en_a = (t >= 5 && t <= 8) ? 4'b0001 : 4'b0010;
      tick();
      eh = (t >= 13) ? 4'h5 : 4'h0;
      checks++;
      if (hip_a[3:0] !== eh || evt_a[0] !== (t == 13)) begin
        errors++;
        $display("FAIL pause t=%0d got code=%h evt=%b exp code=%h evt=%b", t, hip_a[3:0], evt_a[0], eh, (t == 13));
      end
    end
    en_a = 4'b0001; ack_a = 2'b01;
    tick();
    ack_a = 2'b00;
    tick();
    for (int t = 1; t <= 10; t++) begin
      en_a = (t <= 6) ? 4'b0010 : 4'b0000;
      tick();
      checks++;
      if (busy_a[0] !== (t <= 6) || evt_a[0] !== 1'b0 || hip_a[3:0] !== 4'h0) begin
        errors++;
        $display("FAIL cancel t=%0d got busy=%b evt=%b code=%h exp busy=%b evt=0 code=0",
                 t, busy_a[0], evt_a[0], hip_a[3:0], (t <= 6));
      end
    end
  endtask

  task automatic test_independence();
    en_a = 4'b1010;
    for (int t = 1; t <= 9; t++) begin
      car_a = (t == 8) ? 2'b10 : 2'b00;
      tick();
    end
    car_a = 2'b00;
    checks++;
    if (evt_a !== 2'b11 || hip_a !== 8'hF5) begin
      errors++; $display("FAIL indep_both got evt=%b code=%h exp evt=11 code=f5", evt_a, hip_a);
    end
    en_a = 4'b1001; ack_a = 2'b01;
    tick();
    ack_a = 2'b00;
    checks++;
    if (busy_a !== 2'b10 || evt_a !== 2'b00) begin
      errors++; $display("FAIL indep_ack got busy=%b evt=%b exp busy=10 evt=00", busy_a, evt_a);
    end
    tick();
    checks++;
    if (hip_a !== 8'hF0 || busy_a !== 2'b10) begin
      errors++; $display("FAIL indep_hold got code=%h busy=%b exp code=f0 busy=10", hip_a, busy_a);
    end
    en_a = 4'h0;
    repeat (2) tick();
  endtask

  task automatic test_sweep();
    en_b = 8'b0000_0010;
    tick();
    checks++;
    if (busy_b !== 4'b0001 || hip_b !== 16'h0) begin
      errors++; $display("FAIL sweep_arm got busy=%b code=%h exp busy=0001 code=0", busy_b, hip_b);
    end
    tick();
    checks++;
    if (hip_b !== 16'h0005 || evt_b !== 4'b0001) begin
      errors++; $display("FAIL sweep_miss got code=%h evt=%b exp code=0005 evt=0001", hip_b, evt_b);
    end
    ack_b = 4'b0001;
    tick();
    ack_b = 4'b0000;
    checks++;
    if (busy_b !== 4'b0000 || hip_b !== 16'h0 || evt_b !== 4'b0000) begin
      errors++; $display("FAIL sweep_ack got busy=%b code=%h evt=%b exp all 0", busy_b, hip_b, evt_b);
    end
    tick();
    checks++;
    if (busy_b !== 4'b0001) begin errors++; $display("FAIL sweep_rearm got=%b exp=0001", busy_b); end
    tick();
    checks++;
    if (hip_b !== 16'h0005 || evt_b !== 4'b0001) begin
      errors++; $display("FAIL sweep_miss2 got code=%h evt=%b exp code=0005 evt=0001", hip_b, evt_b);
    end
    en_b = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] eh_a, eh_b;
    logic [3:0]  ee_a, ee_b, eb_a, eb_b;
    int r;
    for (int t = 0; t < 400; t++) begin
      for (int l = 0; l < 4; l++) begin
        r = $urandom_range(0, 9);
        en_b[2*l +: 2] = (r == 6) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10;
        if (l < 2) begin
          r = $urandom_range(0, 9);
          en_a[2*l +: 2] = (r == 6) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10;
          car_a[l] = ($urandom_range(0, 7) == 0);
          ack_a[l] = ($urandom_range(0, 3) == 0);
        end
        car_b[l] = ($urandom_range(0, 3) == 0);
        ack_b[l] = ($urandom_range(0, 3) == 0);
      end
      tick();
      eh_a = exp_hip(0); ee_a = exp_evt(0); eb_a = exp_busy(0);
      eh_b = exp_hip(1); ee_b = exp_evt(1); eb_b = exp_busy(1);
      checks++;
      if (hip_a !== eh_a[7:0] || evt_a !== ee_a[1:0] || busy_a !== eb_a[1:0]) begin
        errors++;
        $display("FAIL rand_a t=%0d got code=%h evt=%b busy=%b exp code=%h evt=%b busy=%b",
                 t, hip_a, evt_a, busy_a, eh_a[7:0], ee_a[1:0], eb_a[1:0]);
      end
      checks++;
      if (hip_b !== eh_b || evt_b !== ee_b || busy_b !== eb_b) begin
        errors++;
        $display("FAIL rand_b t=%0d got code=%h evt=%b busy=%b exp code=%h evt=%b busy=%b",
                 t, hip_b, evt_b, busy_b, eh_b, ee_b, eb_b);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_tie();
    test_pause_cancel();
    test_independence();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
